usb_tx_pkt_ctrl: RTL
====================

USB_TX_PKT_CTRL -- requirements
Module: usb_tx_pkt_ctrl

Interface
REQ-001 Parameter BUF_DEPTH, default 64, TX FIFO depth in bytes; OCC_W = $clog2(BUF_DEPTH+1).
REQ-002 Parameter MAX_PKT, default 64, maximum payload bytes per data packet (1..255).
REQ-003 Parameter GAP_CYCLES, default 2, inter-packet holdoff cycles (1..15).
REQ-004 Parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only per REQ-032).
REQ-005 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-006 n_rst  input  1  asynchronous active-low reset.
REQ-007 tx_packet  input  3  request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, 6-7 reserved.
REQ-008 buffer_occupancy  input  OCC_W  bytes currently held in TX FIFO.
REQ-009 byte_req  input  1  encoder ready to accept next payload byte.
REQ-010 end_packet  input  1  encoder finished EOP of current packet.
REQ-011 tx_transfer_active  output  1  packet in progress.
REQ-012 begin_packet  output  1  one-cycle start strobe to encoder.
REQ-013 get_tx_packet_data  output  1  FIFO pop strobe, one per payload byte.
REQ-014 last_byte  output  1  qualifies the final get_tx_packet_data of a packet.
REQ-015 tx_pid_type  output  3  latched packet code of current packet.
REQ-016 tx_error  output  1  registered one-cycle error pulse.

Function
REQ-017 States SHALL be IDLE, BEGIN, SEND, WAIT_EOP, GAP.
REQ-018 New request SHALL be tx_packet != 0 and tx_packet != prev_tx_packet (prev registered every cycle).
REQ-019 IDLE: valid new request -> BEGIN; latch tx_pid_type; latch bytes_left = min(buffer_occupancy, MAX_PKT) for codes 1-2, 0 otherwise.
REQ-020 IDLE: new request with code 6-7, or code 1-2 with buffer_occupancy == 0 -> tx_error next cycle, remain IDLE.
REQ-021 BEGIN: begin_packet = 1 for exactly one cycle; next state SEND for codes 1-2, WAIT_EOP for codes 3-5.
REQ-022 SEND: get_tx_packet_data = byte_req combinationally; each pop decrements bytes_left by 1.
REQ-023 SEND: pop with bytes_left == 1 SHALL assert last_byte in the same cycle and move to WAIT_EOP.
REQ-024 SEND: end_packet before last byte -> tx_error, abort to GAP, no further pops.
REQ-025 WAIT_EOP: end_packet -> GAP; byte_req ignored, no pops.
REQ-026 GAP: hold GAP_CYCLES cycles then IDLE; requests arriving in GAP are not queued (need a new edge per REQ-018).
REQ-027 tx_transfer_active SHALL be 1 in BEGIN, SEND, WAIT_EOP; 0 in IDLE and GAP.
REQ-028 New request while tx_transfer_active or in GAP -> tx_error pulse; current packet unaffected; request dropped.
REQ-029 Simultaneous error sources in one cycle SHALL produce a single tx_error pulse.
REQ-030 bytes_left SHALL be 8 bits and never wrap below 0.

Reset
REQ-031 n_rst low, at any time including mid-packet: state IDLE, prev_tx_packet 0, bytes_left 0, tx_pid_type 0, all outputs 0; no pop after reset release until a new request.

Configuration
REQ-032 Macro USB_TX_TIMEOUT_EN defined: counter clears on every pop/end_packet/state change; reaching TIMEOUT_CYCLES in SEND or WAIT_EOP -> tx_error, go GAP.
REQ-033 Macro USB_TX_TIMEOUT_EN undefined: no watchdog logic; SEND/WAIT_EOP wait indefinitely.

Verification
REQ-034 Occupancy 5, tx_packet 0->1, byte_req held 1 -> begin_packet 1 cycle, 5 pops, last_byte on 5th, end_packet -> GAP 2 cycles -> IDLE, no error.
REQ-035 Occupancy 100, MAX_PKT 64, DATA1 request -> exactly 64 pops, last_byte on 64th.
REQ-036 tx_packet 0->3 (ACK) -> begin_packet, zero pops, WAIT_EOP until end_packet.
REQ-037 tx_packet 0->1 with occupancy 0 -> tx_error one cycle, begin_packet never asserted; code 7 request -> same.
REQ-038 During SEND tx_packet 1->4 -> one tx_error pulse, pop count unchanged; end_packet after 2 of 5 pops -> tx_error, GAP.
REQ-039 n_rst pulsed after 3 pops -> all outputs 0 immediately; with USB_TX_TIMEOUT_EN, byte_req held 0 in SEND for 1024 cycles -> tx_error, GAP.

Source files
------------

// File: rtl/usb_tx_pkt_ctrl.sv
// ============================================================================
// usb_tx_pkt_ctrl
// ----------------------------------------------------------------------------
// Transmit-side packet sequencer for a USB device endpoint. It sits between
// the request source (tx_packet), the TX payload FIFO and the NRZI/bit-stuff
// encoder. It performs these steps for each packet:
//   1. Accepts a packet request on a change of tx_packet.
//   2. Strobes the encoder with begin_packet.
//   3. For DATA0/DATA1 packets, pops up to MAX_PKT payload bytes from the
//      FIFO, paced by byte_req.
//   4. Waits for the encoder's end-of-packet indication.
//   5. Enforces an inter-packet holdoff before returning to idle.
//
// Parameters
//   BUF_DEPTH       TX FIFO depth in bytes (sets the occupancy width OCC_W)
//   MAX_PKT         maximum payload bytes per data packet (1..255)
//   GAP_CYCLES      inter-packet holdoff in clock cycles (1..15)
//   TIMEOUT_CYCLES  watchdog limit, only meaningful with USB_TX_TIMEOUT_EN
//
// Ports
//   clk                 system clock, everything on the rising edge
//   n_rst               asynchronous active-low reset
//   tx_packet[2:0]      request code: 0 none, 1 DATA0, 2 DATA1, 3 ACK,
//                       4 NAK, 5 STALL, 6-7 reserved
//   buffer_occupancy    bytes currently held in the TX FIFO
//   byte_req            encoder ready to take the next payload byte
//   end_packet          encoder finished the EOP of the current packet
//   tx_transfer_active  packet in progress (BEGIN, SEND, WAIT_EOP)
//   begin_packet        one-cycle start strobe to the encoder
//   get_tx_packet_data  FIFO pop strobe, one per payload byte
//   last_byte           qualifies the final pop of a packet
//   tx_pid_type[2:0]    latched code of the current packet
//   tx_error            registered one-cycle error pulse
//
// Configuration
//   Define USB_TX_TIMEOUT_EN to build a watchdog. The watchdog aborts a
//   packet that makes no progress for TIMEOUT_CYCLES cycles while in SEND
//   or WAIT_EOP. Without the macro no watchdog logic exists, and those
//   states wait indefinitely.
// ============================================================================
module usb_tx_pkt_ctrl #(
    parameter int BUF_DEPTH      = 64,
    parameter int MAX_PKT        = 64,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int OCC_W         = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [2:0]       tx_packet,
    input  logic [OCC_W-1:0] buffer_occupancy,
    input  logic             byte_req,
    input  logic             end_packet,
    output logic             tx_transfer_active,
    output logic             begin_packet,
    output logic             get_tx_packet_data,
    output logic             last_byte,
    output logic [2:0]       tx_pid_type,
    output logic             tx_error
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_BEGIN    = 3'd1;
    localparam logic [2:0] ST_SEND     = 3'd2;
    localparam logic [2:0] ST_WAIT_EOP = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    // The occupancy/MAX_PKT comparison is done at whichever width is wider,
    // so that neither side is truncated.
    localparam int CMP_W = (OCC_W > 8) ? OCC_W : 8;

    // The gap counter is loaded with GAP_CYCLES-1 on entry to GAP.
    // GAP therefore lasts exactly GAP_CYCLES cycles.
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [2:0]       prev_tx_packet;
    logic [7:0]       bytes_left;
    logic [3:0]       gap_cnt;

    logic             new_req;
    logic             req_is_data;
    logic             req_reserved;
    logic             idle_bad;
    logic             idle_go;
    logic             busy_req;
    logic             pid_is_data;
    logic             pop;
    logic             abort;
    logic             timeout_hit;
    logic             err_nxt;

    logic [CMP_W-1:0] occ_cmp;
    logic [CMP_W-1:0] max_cmp;
    logic [7:0]       pkt_len;

    // ------------------------------------------------------------------------
    // Request decode.
    // A request is counted only on a change of tx_packet to a nonzero code.
    // A level that is held constant therefore never re-triggers. Requests
    // seen while a packet or the holdoff is running are not queued. They
    // only raise an error.
    // ------------------------------------------------------------------------
    assign new_req      = (tx_packet != 3'd0) && (tx_packet != prev_tx_packet);
    assign req_is_data  = (tx_packet == 3'd1) || (tx_packet == 3'd2);
    assign req_reserved = (tx_packet[2:1] == 2'b11);

    assign idle_bad = (state == ST_IDLE) && new_req &&
                      (req_reserved || (req_is_data && (buffer_occupancy == '0)));
    assign idle_go  = (state == ST_IDLE) && new_req && !idle_bad;
    assign busy_req = new_req && (state != ST_IDLE);

    assign pid_is_data = (tx_pid_type == 3'd1) || (tx_pid_type == 3'd2);

    // ------------------------------------------------------------------------
    // Payload length for a data packet: min(buffer_occupancy, MAX_PKT).
    // When occupancy is the smaller value it is below MAX_PKT <= 255.
    // Its low byte is therefore the whole value.
    // ------------------------------------------------------------------------
    assign occ_cmp = CMP_W'(buffer_occupancy);
    assign max_cmp = CMP_W'(MAX_PKT);
    assign pkt_len = (occ_cmp < max_cmp) ? occ_cmp[7:0] : 8'(MAX_PKT);

    // ------------------------------------------------------------------------
    // Pop and abort.
    // In SEND the FIFO pop follows byte_req combinationally.
    // An end_packet in SEND is an early abort, and it wins over a
    // coincident byte_req, so no byte is popped on the abort cycle.
    // The bytes_left guard keeps the counter from ever wrapping.
    // ------------------------------------------------------------------------
    assign pop   = (state == ST_SEND) && byte_req && !end_packet && (bytes_left != 8'd0);
    assign abort = (state == ST_SEND) && end_packet;

    assign get_tx_packet_data = pop;
    assign last_byte          = pop && (bytes_left == 8'd1);
    assign begin_packet       = (state == ST_BEGIN);
    assign tx_transfer_active = (state == ST_BEGIN) || (state == ST_SEND) ||
                                (state == ST_WAIT_EOP);

    // All error sources are merged here. Simultaneous causes therefore
    // produce a single pulse.
    assign err_nxt = idle_bad | busy_req | abort | timeout_hit;

    // ------------------------------------------------------------------------
    // Next-state logic. A watchdog expiry overrides the normal transition
    // and forces the holdoff.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (idle_go) state_nxt = ST_BEGIN;
            ST_BEGIN:    state_nxt = pid_is_data ? ST_SEND : ST_WAIT_EOP;
            ST_SEND: begin
                if (end_packet)     state_nxt = ST_GAP;
                else if (last_byte) state_nxt = ST_WAIT_EOP;
            end
            ST_WAIT_EOP: if (end_packet) state_nxt = ST_GAP;
            ST_GAP:      if (gap_cnt == 4'd0) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (timeout_hit) state_nxt = ST_GAP;
    end

    // ------------------------------------------------------------------------
    // Main sequential state: FSM, request edge detector, error pulse,
    // latched packet code and remaining-byte counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= ST_IDLE;
            prev_tx_packet <= 3'd0;
            tx_error       <= 1'b0;
            tx_pid_type    <= 3'd0;
            bytes_left     <= 8'd0;
        end else begin
            state          <= state_nxt;
            prev_tx_packet <= tx_packet;
            tx_error       <= err_nxt;
            if (idle_go) begin
                tx_pid_type <= tx_packet;
                bytes_left  <= req_is_data ? pkt_len : 8'd0;
            end else if (pop) begin
                bytes_left  <= bytes_left - 8'd1;
            end else if (state_nxt == ST_GAP) begin
                bytes_left  <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Holdoff counter. It is loaded on entry to GAP and counts down while
    // in GAP. GAP exits when the counter reaches zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gap_cnt <= 4'd0;
        end else if ((state != ST_GAP) && (state_nxt == ST_GAP)) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

`ifdef USB_TX_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Watchdog. It counts cycles without progress in SEND or WAIT_EOP.
    // Any pop, end_packet or state change restarts the count.
    // The expiry strobe fires on the TIMEOUT_CYCLES-th stalled cycle.
    // ------------------------------------------------------------------------
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_watch;

    assign wd_watch    = (state == ST_SEND) || (state == ST_WAIT_EOP);
    assign timeout_hit = wd_watch && !pop && !end_packet &&
                         (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
        end else if (!wd_watch || pop || end_packet || (state_nxt != state)) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    // No watchdog in this build.
    // TIMEOUT_CYCLES is never negative, so this strobe is a constant zero.
    // The parameter is kept so both builds share one interface.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule
